// File: rtl/systolic_tile_loader.sv
// Fetches one N x N operand tile over a fixed-latency read port and
// reassembles it into a flat row-major register held stable after done.
module systolic_tile_loader #(
  parameter int unsigned N              = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned BANKING_FACTOR = 1,
  parameter int unsigned ADDRESS_WIDTH  = 13,
  parameter int unsigned MEM_LATENCY    = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDRESS_WIDTH-1:0]             base_addr,
  output logic                                 busy,
  output logic                                 done,
  output logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
  output logic                                 mem_read_en,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,
  output logic [N*N*DATA_WIDTH-1:0]            tile_out
);

  localparam int unsigned REQS  = N * N / BANKING_FACTOR;
  localparam int unsigned CNT_W = (REQS > 1) ? $clog2(REQS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state, state_d;
  logic [CNT_W-1:0]         req_cnt, req_cnt_d;
  logic [CNT_W-1:0]         cap_cnt;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [MEM_LATENCY-1:0]   pipe;
  logic                     capture;
  logic                     load;

  // Tail of the in-flight pipe marks the cycle whose response is captured.
  assign capture = pipe[MEM_LATENCY-1];
  assign load    = ((state == IDLE) || (state == DONE)) && start;

  always_comb begin
    state_d   = state;
    req_cnt_d = req_cnt;
    addr_d    = mem_req_addr;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d   = ISSUE;
          req_cnt_d = '0;
          addr_d    = base_addr;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (req_cnt == CNT_W'(REQS - 1)) begin
          state_d = DRAIN;
        end else begin
          req_cnt_d = req_cnt + CNT_W'(1);
          addr_d    = mem_req_addr + ADDRESS_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (capture && (cap_cnt == CNT_W'(REQS - 1))) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State plus registered outputs, all decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_cnt      <= '0;
      cap_cnt      <= '0;
      mem_req_addr <= '0;
      mem_read_en  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      req_cnt      <= req_cnt_d;
      mem_req_addr <= addr_d;
      mem_read_en  <= (state_d == ISSUE);
      busy         <= (state_d == ISSUE) || (state_d == DRAIN);
      done         <= (state_d == DONE);
      if (load) begin
        cap_cnt <= '0;
      end else if (capture) begin
        cap_cnt <= cap_cnt + CNT_W'(1);
      end
    end
  end

  if (MEM_LATENCY > 1) begin : g_pipe_deep
    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe <= '0;
      else     pipe <= {pipe[MEM_LATENCY-2:0], mem_read_en};
    end
  end else begin : g_pipe_single
    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe <= '0;
      else     pipe <= mem_read_en;
    end
  end

  // Word k, lane b lands in element k*BANKING_FACTOR+b.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_out <= '0;
    end else if (capture) begin
      for (int b = 0; b < int'(BANKING_FACTOR); b++) begin
        tile_out[(int'(cap_cnt) * int'(BANKING_FACTOR) + b) * int'(DATA_WIDTH) +: DATA_WIDTH]
          <= mem_resp_data[b * int'(DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_systolic_tile_loader.sv
// Bench for systolic_tile_loader: a default instance (BF=1, latency 3) and a
// banked instance (BF=2, latency 1) checked every cycle against a schedule model.
module tb_systolic_tile_loader;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_v [2];
  logic [12:0]   base_v  [2];

  logic          busy_a, done_a, ren_a;
  logic [12:0]   addr_a;
  logic [15:0]   resp_a;
  logic [255:0]  tile_a;
  logic          busy_b, done_b, ren_b;
  logic [12:0]   addr_b;
  logic [31:0]   resp_b;
  logic [255:0]  tile_b;

  systolic_tile_loader dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .base_addr(base_v[0]),
    .busy(busy_a), .done(done_a), .mem_req_addr(addr_a), .mem_read_en(ren_a),
    .mem_resp_data(resp_a), .tile_out(tile_a)
  );

  systolic_tile_loader #(.BANKING_FACTOR(2), .MEM_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .base_addr(base_v[1]),
    .busy(busy_b), .done(done_b), .mem_req_addr(addr_b), .mem_read_en(ren_b),
    .mem_resp_data(resp_b), .tile_out(tile_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  bit           have     [2];
  int           s_cyc    [2];
  logic [12:0]  b0       [2];
  logic [255:0] exp_tile [2];
  logic         hist_en   [2][64];
  logic [12:0]  hist_addr [2][64];

  function automatic int lat(int ch);
    return (ch == 0) ? 3 : 1;
  endfunction

  function automatic int bf(int ch);
    return (ch == 0) ? 1 : 2;
  endfunction

  function automatic int reqs(int ch);
    return 16 / bf(ch);
  endfunction

  // Mock memory contents: lane 0 of word a is a+1, lane 1 is a+0x4001.
  function automatic logic [31:0] word(int ch, logic [12:0] a);
    logic [15:0] lo, hi;
    lo = 16'(a) + 16'h0001;
    hi = 16'(a) + 16'h4001;
    return (ch == 0) ? {16'h0000, lo} : {hi, lo};
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  always @(posedge rst) begin
    for (int ch = 0; ch < 2; ch++) begin
      have[ch]     = 1'b0;
      exp_tile[ch] = '0;
    end
  end

  // Model: captures and start acceptance at the edge ending cycle cyc.
  always @(posedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        int rel, k;
        logic [31:0] w;
        if (have[ch]) begin
          rel = cyc - s_cyc[ch];
          if (rel >= 1 + lat(ch) && rel <= reqs(ch) + lat(ch)) begin
            k = rel - 1 - lat(ch);
            w = word(ch, b0[ch] + 13'(k));
            for (int b = 0; b < bf(ch); b++)
              exp_tile[ch][(k * bf(ch) + b) * 16 +: 16] = w[b * 16 +: 16];
          end
        end
        if (start_v[ch] && (!have[ch] || (cyc - s_cyc[ch]) >= reqs(ch) + lat(ch) + 1)) begin
          have[ch]  = 1'b1;
          s_cyc[ch] = cyc;
          b0[ch]    = base_v[ch];
        end
      end
    end
    cyc++;
  end

  // Memory responder plus per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    hist_en[0][cyc % 64]   = ren_a;
    hist_addr[0][cyc % 64] = addr_a;
    hist_en[1][cyc % 64]   = ren_b;
    hist_addr[1][cyc % 64] = addr_b;
    for (int ch = 0; ch < 2; ch++) begin
      int idx, rel;
      logic [31:0] w;
      logic e_busy, e_ren, e_done;
      logic [12:0] e_addr;
      logic d_busy, d_ren, d_done;
      logic [12:0] d_addr;
      logic [255:0] d_tile;
      idx = (cyc + 64 - lat(ch)) % 64;
      if (hist_en[ch][idx] === 1'b1) w = word(ch, hist_addr[ch][idx]);
      else w = $urandom;
      if (ch == 0) resp_a = w[15:0];
      else resp_b = w;
      e_busy = 1'b0; e_ren = 1'b0; e_done = 1'b0; e_addr = '0;
      if (have[ch]) begin
        rel    = cyc - s_cyc[ch];
        e_busy = (rel >= 1) && (rel <= reqs(ch) + lat(ch));
        e_ren  = (rel >= 1) && (rel <= reqs(ch));
        e_done = (rel == reqs(ch) + lat(ch) + 1);
        e_addr = b0[ch] + 13'(rel - 1);
      end
      d_busy = (ch == 0) ? busy_a : busy_b;
      d_ren  = (ch == 0) ? ren_a  : ren_b;
      d_done = (ch == 0) ? done_a : done_b;
      d_addr = (ch == 0) ? addr_a : addr_b;
      d_tile = (ch == 0) ? tile_a : tile_b;
      chk($sformatf("busy%0d", ch), 256'(d_busy), 256'(e_busy));
      chk($sformatf("read_en%0d", ch), 256'(d_ren), 256'(e_ren));
      chk($sformatf("done%0d", ch), 256'(d_done), 256'(e_done));
      if (e_ren) chk($sformatf("addr%0d", ch), 256'(d_addr), 256'(e_addr));
      chk($sformatf("tile%0d", ch), d_tile, exp_tile[ch]);
    end
  end

  task automatic at(int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      start_v[ch] = 1'b0; base_v[ch] = '0; have[ch] = 1'b0; exp_tile[ch] = '0;
      for (int i = 0; i < 64; i++) begin hist_en[ch][i] = 1'b0; hist_addr[ch][i] = '0; end
    end
    resp_a = '0; resp_b = '0;
    at(2); rst = 1'b0;

    // Load from 0x100 on A and 0x040 on B, start sampled at edge 5.
    at(5); start_v[0] = 1'b1; base_v[0] = 13'h100; start_v[1] = 1'b1; base_v[1] = 13'h040;
    at(6); start_v[0] = 1'b0; start_v[1] = 1'b0;
    chk("t1_first_addr", 256'(addr_a), 256'(13'h100));
    chk("t1_first_ren", 256'(ren_a), 256'(1'b1));
    at(10); start_v[0] = 1'b1; base_v[0] = 13'h000;
    at(11); start_v[0] = 1'b0;
    chk("t2_addr_unaffected", 256'(addr_a), 256'(13'h105));
    at(14); chk("t6_done_early", 256'(done_b), 256'(1'b0));
    at(15); chk("t6_done", 256'(done_b), 256'(1'b1));
    chk("t6_lane1_word0", 256'(tile_b[31:16]), 256'(16'h4041));
    chk("t6_lane0_word1", 256'(tile_b[47:32]), 256'(16'h0042));
    at(17); start_v[0] = 1'b1;
    at(18); start_v[0] = 1'b0;
    at(24); chk("t1_done_early", 256'(done_a), 256'(1'b0));
    chk("t1_busy_last", 256'(busy_a), 256'(1'b1));
    at(25); chk("t1_done", 256'(done_a), 256'(1'b1));
    chk("t1_elem0", 256'(tile_a[15:0]), 256'(16'h0101));
    chk("t1_elem_r1c2", 256'(tile_a[111:96]), 256'(16'h0107));
    chk("t1_elem15", 256'(tile_a[255:240]), 256'(16'h0110));

    // Async reset in the middle of cycle 9 of a load.
    at(30); start_v[0] = 1'b1; base_v[0] = 13'h300;
    at(31); start_v[0] = 1'b0;
    at(39); #3 rst = 1'b1;
    #1;
    chk("t3_rst_busy", 256'(busy_a), 256'(1'b0));
    chk("t3_rst_ren", 256'(ren_a), 256'(1'b0));
    chk("t3_rst_addr", 256'(addr_a), 256'(13'h000));
    chk("t3_rst_tile", tile_a, 256'(0));
    at(41); rst = 1'b0;
    at(45); start_v[0] = 1'b1; base_v[0] = 13'h000;
    at(46); start_v[0] = 1'b0;
    at(64); chk("t3_done_early", 256'(done_a), 256'(1'b0));
    at(65); chk("t3_done", 256'(done_a), 256'(1'b1));
    chk("t3_elem0", 256'(tile_a[15:0]), 256'(16'h0001));
    chk("t3_elem15", 256'(tile_a[255:240]), 256'(16'h0010));

    // Address wrap at the top of the address space.
    at(70); start_v[0] = 1'b1; base_v[0] = 13'h1FFE;
    at(71); start_v[0] = 1'b0;
    chk("t4_addr0", 256'(addr_a), 256'(13'h1FFE));
    at(73); chk("t4_addr2", 256'(addr_a), 256'(13'h0000));
    at(90); chk("t4_done", 256'(done_a), 256'(1'b1));
    chk("t4_elem0", 256'(tile_a[15:0]), 256'(16'h1FFF));
    chk("t4_elem2", 256'(tile_a[47:32]), 256'(16'h0001));

    // start held high: back-to-back load launched from the DONE cycle.
    at(95); start_v[0] = 1'b1; base_v[0] = 13'h200;
    at(96); base_v[0] = 13'h280;
    at(115); chk("t5_done1", 256'(done_a), 256'(1'b1));
    chk("t5_ren_in_done", 256'(ren_a), 256'(1'b0));
    at(116); chk("t5_second_ren", 256'(ren_a), 256'(1'b1));
    chk("t5_second_addr", 256'(addr_a), 256'(13'h280));
    at(135); chk("t5_done2", 256'(done_a), 256'(1'b1));
    start_v[0] = 1'b0;
    at(136); chk("t5_idle", 256'(busy_a), 256'(1'b0));

    // Randomized starts and bases on both instances, with one reset.
    for (int c = 140; c < 940; c++) begin
      at(c);
      if (c == 500) begin
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        #3 rst = 1'b1;
      end else if (c == 502) begin
        rst = 1'b0;
      end else if (!rst) begin
        for (int ch = 0; ch < 2; ch++) begin
          start_v[ch] = (($urandom % 6) == 0);
          base_v[ch]  = 13'($urandom);
        end
      end
    end
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    at(960);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/systolic_tile_loader.md
Name: systolic_tile_loader

Overview:
- Upstream feeder for the systolic wrapper. On `start`, fetches one N×N operand tile (weights or activations) from word-addressed memory through the shared fixed-latency read port.
- Reassembles returned words into a flat row-major tile register.
- Holds the tile stable for the array and pulses `done`.
- Two instances, one at base_addr_w and one at base_addr_x, feed the array's W and X inputs.

Parameters:
- N, 4, tile dimension (tile has N*N elements)
- DATA_WIDTH, 16, bits per element
- BANKING_FACTOR, 1, elements returned per memory word; N*N must be a multiple of it
- ADDRESS_WIDTH, 13, memory word-address width
- MEM_LATENCY, 3, cycles from a request cycle to its response cycle; minimum 1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a load; sampled only in IDLE or DONE
- base_addr  in  ADDRESS_WIDTH  first word address; sampled with start
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse when the tile is complete
- mem_req_addr  out  ADDRESS_WIDTH  read word address
- mem_read_en  out  1  read request valid
- mem_resp_data  in  BANKING_FACTOR*DATA_WIDTH  read data, valid exactly MEM_LATENCY cycles after the request cycle
- tile_out  out  N*N*DATA_WIDTH  element (r,c) at bits [(r*N+c)*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Derived constant: REQS = N*N/BANKING_FACTOR.
- Reset (async assert, sync release):
  - state=IDLE; busy=0, done=0, mem_read_en=0, mem_req_addr=0, tile_out=0.
  - Request counter, capture counter and in-flight pipeline cleared.
  - Responses still in flight are discarded.
- States:
  - IDLE: start=1 latches base_addr and goes to ISSUE.
  - ISSUE: mem_read_en=1 every cycle. mem_req_addr = base_addr + i for request i = 0..REQS-1. After request REQS-1 goes to DRAIN.
  - DRAIN: mem_read_en=0; waits for the remaining responses. When capture REQS-1 occurs, goes to DONE.
  - DONE: done=1 for exactly this cycle. start=1 here behaves as in IDLE (back-to-back load); otherwise goes to IDLE.
  - start while busy=1 is ignored, and base_addr is not re-sampled.
- Response tracking:
  - A MEM_LATENCY-deep valid shift register records which cycles carry a request.
  - Its tail marks the cycle in which mem_resp_data is captured.
  - Responses arrive in request order, so capture k stores word k.
  - Lane b of word k, bits [b*DATA_WIDTH +: DATA_WIDTH], goes to element index k*BANKING_FACTOR+b.
- Timing: with start sampled at edge 0:
  - Requests occur in cycles 1..REQS.
  - Captures occur in cycles 1+MEM_LATENCY .. REQS+MEM_LATENCY.
  - done is high in cycle REQS+MEM_LATENCY+1. For the defaults: REQS=16, done in cycle 20.
- tile_out:
  - Updated element-by-element during a load.
  - Stable from done until the first capture of the next load.
  - Not cleared at the start of a new load.
- Address arithmetic is modulo 2^ADDRESS_WIDTH: base 13'h1FFE with REQS=4 issues 1FFE, 1FFF, 0000, 0001.
- The loader never writes memory; the wrapper muxes this port's mem_req_addr/mem_read_en with its own write path.
- Reset mid-load returns to IDLE at once. A new start after reset performs a full clean load, with no stale captures from the aborted load.

Test Plan:
1. Defaults, mock memory with word[a]=a+1, base_addr=13'h100, start pulsed one cycle -> mem_read_en high cycles 1..16 with addresses 100..10F; done high only in cycle 20; busy high cycles 1..19; tile_out element (r,c)=0x101+r*4+c.
2. start re-pulsed in cycles 5 and 12 with base_addr=13'h000 -> no effect: addresses continue 105.., done still only in cycle 20, tile from 0x100.
3. rst asserted asynchronously mid-cycle 9 -> outputs 0 immediately, including tile_out. A later start with base 13'h000 yields tile element i = i+1 and done exactly 20 cycles after that start.
4. base_addr=13'h1FFE -> addresses 1FFE, 1FFF, 0000..000D; tile element 0 = word[1FFE], element 2 = word[0000].
5. start held high through done -> second load begins in the DONE cycle (next request the following cycle); done pulses at cycle 20 and cycle 40; tile stable between cycle 20 and that second load's first capture.
6. BANKING_FACTOR=2, MEM_LATENCY=1 -> 8 requests, done in cycle 10; lane 0 of word k lands in element 2k and lane 1 in element 2k+1.
